clk_div_multi: RTL
==================

# clk_div_multi

Parametrised multi-channel clock divider generating `N_CH` independent divided clock/enable outputs from the system clock. Each channel has a runtime-programmable half-period count, loaded through a simple write port and applied glitch-free at the channel's next terminal count, plus a per-channel enable and a global phase-align input. It supplies slow timing sources to blink, scan and peripheral-timing logic, so those blocks no longer need their own fixed-count dividers.

## Interface
- `N_CH`, default 4: number of divider channels (1..16).
- `CNT_W`, default 24: counter and divisor width in bits.
- `DEFAULT_DIV`, default 5000000: reset value of every channel's divisor (must fit in `CNT_W`).
- `SEL_W`, default 2: channel-select width, set to max(1, clog2(`N_CH`)).

- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in `N_CH`: per-channel run enable, level-sensitive.
- `wr_en` in 1: divisor write strobe, one write per cycle.
- `wr_sel` in `SEL_W`: channel index for the write.
- `wr_data` in `CNT_W`: new divisor value.
- `sync` in 1: single-cycle phase-align pulse for all channels.
- `sclk` out `N_CH`: divided clock per channel (registered).
- `tick` out `N_CH`: one-cycle pulse per channel on every `sclk` toggle (registered).

## Operation
- Per channel state: `cnt` (`CNT_W`), `div_shadow` (written value), `div_act` (value in use), `sclk`, `tick`.
- Write: `wr_en`=1 with `wr_sel` < `N_CH` updates `div_shadow[wr_sel]` <= `wr_data`. `wr_sel` >= `N_CH` is ignored with no side effect.
- Running (`en[i]`=1, `sync`=0):
  - If `cnt` == `div_act`: `sclk` <= ~`sclk`, `tick` <= 1, `cnt` <= 0, `div_act` <= `div_shadow`.
  - Otherwise: `cnt` <= `cnt`+1, `tick` <= 0.
- Output period is 2*(`div_act`+1) clocks at 50% duty. Divisor 0 toggles `sclk` every cycle (period 2).
- Divisor change takes effect only at a terminal count, so no truncated half-period is ever produced.
- Write and terminal count in the same cycle: `div_act` loads the pre-write `div_shadow`. The new value applies at the following terminal count.
- Disabled (`en[i]`=0): `cnt` <= 0, `sclk` <= 0, `tick` <= 0, and `div_act` <= `div_shadow` every cycle. Writes still accepted.
- Re-enable: the first toggle (`sclk` 0->1) occurs `div_act`+1 cycles after the first cycle with `en[i]`=1.
- `sync`=1: every channel does `cnt` <= 0, `sclk` <= 0, `tick` <= 0, `div_act` <= `div_shadow`. `sync` overrides the terminal-count action. All enabled channels then restart in phase.
- Counter compares with equality only. A `div_act` reached at any `cnt` value is safe because `cnt` is reset on every load path.

## Timing
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `sclk`=0, `tick`=0, `div_shadow`=`div_act`=`DEFAULT_DIV`, all channels.
- Reset deassertion is taken synchronously by the first rising edge. A channel with `en`=1 toggles `sclk` high at edge `DEFAULT_DIV`+1 after release.
- Reset mid-period returns the channel to the reset state immediately, with no glitch pulse on `tick`.
- Latency:
  - `tick` is high in exactly the cycle `sclk` shows its new value.
  - `en` and `sync` act on the next edge (1-cycle latency).
  - Write to first use: at least 1 cycle, at most `div_act`+2 cycles.
- Inputs are synchronous to `clk`. Asynchronous sources must be synchronised upstream.

## Test plan
- Reset: hold `rst_n`=0 with `en`=all ones -> `sclk`=0 and `tick`=0. After release with `DEFAULT_DIV` overridden to 3, `sclk` ch0 rises at edge 4 and falls at edge 8, period 8, `tick` high on edges 4 and 8 only.
- Runtime change: `DEFAULT_DIV`=3, write 1 to ch0 at cycle 2 -> first half-period remains 4 cycles, subsequent half-periods 2 cycles. Ch1..3 unaffected.
- Divisor 0 and collision: write 0 in the same cycle as a ch1 terminal count -> next half-period uses the old value, then `sclk` ch1 toggles every cycle with `tick` held high.
- Enable gating: drop `en[2]` mid-period -> next edge `sclk[2]`=0, `cnt`=0. Re-assert -> first rise after `div_act`+1 cycles.
- Sync: channels with divisors 2 and 5, pulse `sync` -> both `sclk`=0 next edge, both rising edges then land at 3 and 6 cycles after sync. Invalid `wr_sel`=3 with `N_CH`=3 -> no register changes.
- Async reset asserted mid-period between clock edges -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel half-period counters with
// shadowed divisors that are only swapped in at terminal count, sync or disable.
module clk_div_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 24,
    parameter int DEFAULT_DIV = 5000000,
    parameter int SEL_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             sync,
    output logic [N_CH-1:0]  sclk,
    output logic [N_CH-1:0]  tick
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [CNT_W-1:0] shadow_q [N_CH];
    logic [CNT_W-1:0] shadow_d [N_CH];
    logic [CNT_W-1:0] act_q    [N_CH];
    logic [CNT_W-1:0] act_d    [N_CH];
    logic [N_CH-1:0]  sclk_q, sclk_d;
    logic [N_CH-1:0]  tick_q, tick_d;

    always_comb begin
        sclk_d = sclk_q;
        tick_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            act_d[i]    = act_q[i];
            cnt_d[i]    = cnt_q[i];

            // Out-of-range selects match no channel and are silently dropped.
            if (wr_en && (wr_sel == SEL_W'(i))) begin
                shadow_d[i] = wr_data;
            end

            // Every path that reloads act_q also clears cnt_q, so equality compare is safe.
            if (sync || !en[i]) begin
                cnt_d[i]  = '0;
                sclk_d[i] = 1'b0;
                act_d[i]  = shadow_q[i];
            end else if (cnt_q[i] == act_q[i]) begin
                cnt_d[i]  = '0;
                sclk_d[i] = ~sclk_q[i];
                tick_d[i] = 1'b1;
                act_d[i]  = shadow_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            tick_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= DIV_RST;
                act_q[i]    <= DIV_RST;
            end
        end else begin
            sclk_q <= sclk_d;
            tick_q <= tick_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
                act_q[i]    <= act_d[i];
            end
        end
    end

    assign sclk = sclk_q;
    assign tick = tick_q;

endmodule
